// File: rtl/phy_rx_lane_deser.sv
// Serial-to-byte receiver for one phy_tx lane: comma-based byte alignment, then data bytes with a one-cycle strobe.
// Latency: strobe/data visible the cycle after the edge that samples a byte's LSB; no backpressure (free-running bit stream).
module phy_rx_lane_deser #(
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter int         SYNC_COMMAS = 4,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic             active,
    output logic [CNT_W-1:0] byte_cnt
);

    localparam int BC_W = $clog2(SYNC_COMMAS + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(SYNC_COMMAS - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]  bc_cnt_q, bc_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

    logic [7:0] nsr;
    logic       boundary;
    logic       is_comma;

    // The byte under test includes the bit sampled on this very edge.
    assign nsr      = {sr_q[6:0], data_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign is_comma = (nsr == COMMA);

    always_comb begin
        state_d    = state_q;
        sr_d       = nsr;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        bc_cnt_d   = bc_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        active_d   = active_q;
        byte_cnt_d = byte_cnt_q;

        unique case (state_q)
            SEARCH: begin
                if (is_comma) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = BC_W'(1);
                    if (SYNC_COMMAS == 1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_cnt_q + BC_W'(1);
                        if (bc_cnt_q == BC_LAST) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        state_d  = SEARCH;
                        bc_cnt_d = '0;
                    end
                end
            end
            ACTIVE: begin
                // Idle commas are swallowed; data_out keeps the last real byte.
                if (boundary && !is_comma) begin
                    data_d  = nsr;
                    valid_d = 1'b1;
                    if (byte_cnt_q != {CNT_W{1'b1}}) begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            sr_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            bc_cnt_q   <= '0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            bc_cnt_q   <= bc_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;
    assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_phy_rx_lane_deser.sv
// Bench for phy_rx_lane_deser: vector table, hand-written corner sequences and random traffic
// against a bit-position reference model; a 4-bit-counter instance shares the stimulus.
module tb_phy_rx_lane_deser;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam int         SYNC  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        data_in = 1'b0;
    logic [7:0]  data_out, data_out_s;
    logic        valid_out, valid_out_s;
    logic        active, active_s;
    logic [15:0] byte_cnt;
    logic [3:0]  byte_cnt_s;

    phy_rx_lane_deser #(.COMMA(COMMA), .SYNC_COMMAS(SYNC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .data_out(data_out), .valid_out(valid_out), .active(active), .byte_cnt(byte_cnt)
    );

    phy_rx_lane_deser #(.COMMA(COMMA), .SYNC_COMMAS(SYNC), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .data_in(data_in),
        .data_out(data_out_s), .valid_out(valid_out_s), .active(active_s), .byte_cnt(byte_cnt_s)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: alignment tracked as a bit distance from the first accepted comma.
    logic [7:0] m_sh;
    int         m_pos;
    int         m_commas;
    bit         m_lock;
    logic [7:0] m_data;
    bit         m_valid;
    int         m_cnt;

    int cyc, t_act, t_p1, t_p2, npulse;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mdl_reset();
        m_sh = 8'h00; m_pos = -1; m_commas = 0; m_lock = 0;
        m_data = 8'h00; m_valid = 0; m_cnt = 0;
        cyc = 0; t_act = -1; t_p1 = -1; t_p2 = -1; npulse = 0;
    endtask

    task automatic mdl_step(input logic b);
        m_sh = {m_sh[6:0], b};
        m_valid = 0;
        if (m_pos < 0) begin
            if (m_sh == COMMA) begin
                m_pos = 0;
                m_commas = 1;
                m_lock = (SYNC == 1);
            end
        end else begin
            m_pos++;
            if (m_pos % 8 == 0) begin
                if (!m_lock) begin
                    if (m_sh == COMMA) begin
                        m_commas++;
                        if (m_commas >= SYNC) m_lock = 1;
                    end else begin
                        m_pos = -1;
                        m_commas = 0;
                    end
                end else if (m_sh != COMMA) begin
                    m_data = m_sh;
                    m_valid = 1;
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic send_bit(input logic b);
        logic [15:0] e16;
        logic [3:0]  e4;
        data_in = b;
        @(posedge clk);
        mdl_step(b);
        #1;
        e16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        e4  = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
        chk("cycle", {24'h0, valid_out, data_out, active, byte_cnt,
                      valid_out_s, data_out_s, active_s, byte_cnt_s},
                     {24'h0, m_valid, m_data, m_lock, e16, m_valid, m_data, m_lock, e4});
        if (active && t_act < 0) t_act = cyc;
        if (valid_out) begin
            if (npulse == 0) t_p1 = cyc;
            else if (npulse == 1) t_p2 = cyc;
            npulse++;
        end
        cyc++;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b1;
        mdl_reset();
        #3;
        reset = 1'b0;
    endtask

    typedef struct {
        int          npre;
        logic [7:0]  pre;
        int          nby;
        logic [95:0] by;
        logic        exp_active;
        int          exp_cnt;
        logic [7:0]  exp_data;
        int          exp_pulses;
        int          exp_act_bit;
        int          exp_a2p;
        int          exp_gap;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] rb;
        mdl_reset();

        vecs[0] = '{npre: 3, pre: 8'b101, nby: 5,
                    by: {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 56'h0},
                    exp_active: 1, exp_cnt: 1, exp_data: 8'hA5, exp_pulses: 1,
                    exp_act_bit: 34, exp_a2p: 8, exp_gap: 0};
        vecs[1] = '{npre: 0, pre: 8'h0, nby: 9,
                    by: {8'hBC, 8'hBC, 8'hBC, 8'h12, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 24'h0},
                    exp_active: 1, exp_cnt: 0, exp_data: 8'h00, exp_pulses: 0,
                    exp_act_bit: 63, exp_a2p: 0, exp_gap: 0};
        vecs[2] = '{npre: 0, pre: 8'h0, nby: 8,
                    by: {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 8'hBC, 8'hBC, 8'h3C, 32'h0},
                    exp_active: 1, exp_cnt: 2, exp_data: 8'h3C, exp_pulses: 2,
                    exp_act_bit: 31, exp_a2p: 8, exp_gap: 24};
        vecs[3] = '{npre: 0, pre: 8'h0, nby: 6,
                    by: {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 48'h0},
                    exp_active: 1, exp_cnt: 0, exp_data: 8'h00, exp_pulses: 0,
                    exp_act_bit: 31, exp_a2p: 0, exp_gap: 0};

        // Power-on reset values, before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("por_outputs", {data_out, valid_out, active, byte_cnt, byte_cnt_s}, 64'h0);
        #2 reset = 1'b0;

        // Vector table
        foreach (vecs[k]) begin
            apply_reset();
            for (int i = vecs[k].npre - 1; i >= 0; i--) send_bit(vecs[k].pre[i]);
            for (int i = 0; i < vecs[k].nby; i++) send_byte(vecs[k].by[95 - 8*i -: 8]);
            chk($sformatf("v%0d_active", k), active, vecs[k].exp_active);
            chk($sformatf("v%0d_cnt", k), byte_cnt, vecs[k].exp_cnt);
            chk($sformatf("v%0d_cnt_s", k), byte_cnt_s, vecs[k].exp_cnt);
            chk($sformatf("v%0d_data", k), data_out, vecs[k].exp_data);
            chk($sformatf("v%0d_pulses", k), npulse, vecs[k].exp_pulses);
            chk($sformatf("v%0d_act_bit", k), t_act, vecs[k].exp_act_bit);
            if (vecs[k].exp_pulses >= 1) chk($sformatf("v%0d_act2pulse", k), t_p1 - t_act, vecs[k].exp_a2p);
            if (vecs[k].exp_pulses >= 2) chk($sformatf("v%0d_gap", k), t_p2 - t_p1, vecs[k].exp_gap);
        end

        // Asynchronous reset mid-byte while ACTIVE
        apply_reset();
        repeat (4) send_byte(COMMA);
        send_byte(8'hA5);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        chk("pre_reset_active", active, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_data", data_out, 8'h00);
        chk("async_rst_valid", valid_out, 1'b0);
        chk("async_rst_active", active, 1'b0);
        chk("async_rst_cnt", {byte_cnt, byte_cnt_s}, 20'h0);
        mdl_reset();
        #2 reset = 1'b0;

        // Counter saturation on the 4-bit instance
        apply_reset();
        repeat (4) send_byte(COMMA);
        for (int i = 1; i <= 20; i++) send_byte(8'(i));
        chk("sat_cnt_s", byte_cnt_s, 4'hF);
        chk("sat_cnt", byte_cnt, 16'd20);
        chk("sat_data_s", data_out_s, 8'h14);

        // Reset in ACTIVE, then a short preamble must not relock
        apply_reset();
        repeat (4) send_byte(COMMA);
        send_byte(8'h77);
        send_byte(8'h88);
        chk("t6_cnt_before", byte_cnt, 16'd2);
        apply_reset();
        send_byte(COMMA);
        send_byte(COMMA);
        send_byte(8'h55);
        chk("t6_no_lock", active, 1'b0);
        chk("t6_no_strobe", npulse, 0);
        chk("t6_cnt", byte_cnt, 16'd0);
        repeat (3) send_byte(COMMA);
        chk("t6_three_bc", active, 1'b0);
        send_byte(COMMA);
        chk("t6_relock", active, 1'b1);
        send_byte(8'h66);
        chk("t6_data", data_out, 8'h66);
        chk("t6_cnt_after", byte_cnt, 16'd1);

        // Random traffic: junk bits, preamble, mixed idle/data bytes
        for (int r = 0; r < 3; r++) begin
            apply_reset();
            repeat ($urandom_range(0, 20)) send_bit(1'($urandom));
            repeat (4) send_byte(COMMA);
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    send_byte(COMMA);
                end else begin
                    rb = 8'($urandom);
                    if (rb == COMMA) rb = 8'h00;
                    send_byte(rb);
                end
            end
            chk($sformatf("rnd%0d_active", r), active, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
